// File: rtl/bdd_pkg.sv
// Shared types and widths for the BDD tree walker: FSM state encoding,
// datapath widths and the node-table record layout.
package bdd_pkg;

    localparam int ACC_WIDTH       = 20;
    localparam int NODE_ADDR_WIDTH = 8;
    localparam int CLASS_WIDTH     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT,
        ST_DECIDE,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef struct packed {
        logic [ACC_WIDTH-1:0]       thr;
        logic [NODE_ADDR_WIDTH-1:0] left;
        logic [NODE_ADDR_WIDTH-1:0] right;
        logic                       is_leaf;
        logic [CLASS_WIDTH-1:0]     cls;
    } node_t;

endpackage

// File: rtl/bdd_node_cmp.sv
// Combinational node decision: unsigned accumulator vs threshold compare,
// selecting the right child on acc >= thr and the left child otherwise.
module bdd_node_cmp
    import bdd_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]       acc,
    input  logic [ACC_WIDTH-1:0]       thr,
    input  logic [NODE_ADDR_WIDTH-1:0] left,
    input  logic [NODE_ADDR_WIDTH-1:0] right,
    output logic [NODE_ADDR_WIDTH-1:0] child
);

    assign child = (acc >= thr) ? right : left;

endmodule

// File: rtl/bdd_tree_walker.sv
// Root-to-leaf traversal controller: fetches a node, waits for the MAC result,
// picks a child and repeats until a leaf label is emitted or an error fires.
module bdd_tree_walker
    import bdd_pkg::*;
#(
    parameter int MAX_DEPTH = 15,
    parameter int TIMEOUT   = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic [NODE_ADDR_WIDTH-1:0] node_addr,
    output logic                       node_req,
    input  logic [ACC_WIDTH-1:0]       node_thr,
    input  logic [NODE_ADDR_WIDTH-1:0] node_left,
    input  logic [NODE_ADDR_WIDTH-1:0] node_right,
    input  logic                       node_is_leaf,
    input  logic [CLASS_WIDTH-1:0]     node_class,
    input  logic [ACC_WIDTH-1:0]       acc,
    input  logic                       acc_valid,
    output logic [CLASS_WIDTH-1:0]     class_out,
    output logic                       class_valid,
    output logic                       err
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int TO_W    = $clog2(TIMEOUT + 1);

    state_t                     state_q, state_d;
    logic [NODE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DEPTH_W-1:0]         depth_q, depth_d;
    logic [TO_W-1:0]            to_q, to_d;
    logic [ACC_WIDTH-1:0]       thr_q, thr_d;
    logic [NODE_ADDR_WIDTH-1:0] left_q, left_d;
    logic [NODE_ADDR_WIDTH-1:0] right_q, right_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic [CLASS_WIDTH-1:0]     class_q, class_d;
    logic [NODE_ADDR_WIDTH-1:0] child_addr;

    bdd_node_cmp u_cmp (
        .acc   (acc_q),
        .thr   (thr_q),
        .left  (left_q),
        .right (right_q),
        .child (child_addr)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        depth_d = depth_q;
        to_d    = to_q;
        thr_d   = thr_q;
        left_d  = left_q;
        right_d = right_q;
        acc_d   = acc_q;
        class_d = class_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                    depth_d = '0;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                thr_d   = node_thr;
                left_d  = node_left;
                right_d = node_right;
                to_d    = '0;
                if (node_is_leaf) begin
                    class_d = node_class;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (acc_valid) begin
                    acc_d   = acc;
                    state_d = ST_DECIDE;
                end else begin
                    to_d = to_q + 1'b1;
                    if (to_d == TO_W'(TIMEOUT)) state_d = ST_ERROR;
                end
            end
            ST_DECIDE: begin
                addr_d  = child_addr;
                depth_d = depth_q + 1'b1;
                state_d = (depth_d == DEPTH_W'(MAX_DEPTH)) ? ST_ERROR : ST_FETCH;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            depth_q <= '0;
            to_q    <= '0;
            thr_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            acc_q   <= '0;
            class_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            depth_q <= depth_d;
            to_q    <= to_d;
            thr_q   <= thr_d;
            left_q  <= left_d;
            right_q <= right_d;
            acc_q   <= acc_d;
            class_q <= class_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign node_req    = (state_q == ST_FETCH);
    assign class_valid = (state_q == ST_DONE);
    assign err         = (state_q == ST_ERROR);
    assign node_addr   = addr_q;
    assign class_out   = class_q;

endmodule

// File: tb/tb_bdd_tree_walker.sv
// Directed bench for bdd_tree_walker: a node-table/MAC responder model plus
// table-driven two-level trees and hand-written multi-cycle sequences.
module tb_bdd_tree_walker;
    import bdd_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic                       busy;
    logic [NODE_ADDR_WIDTH-1:0] node_addr;
    logic                       node_req;
    logic [ACC_WIDTH-1:0]       node_thr;
    logic [NODE_ADDR_WIDTH-1:0] node_left;
    logic [NODE_ADDR_WIDTH-1:0] node_right;
    logic                       node_is_leaf;
    logic [CLASS_WIDTH-1:0]     node_class;
    logic [ACC_WIDTH-1:0]       acc;
    logic                       acc_valid;
    logic [CLASS_WIDTH-1:0]     class_out;
    logic                       class_valid;
    logic                       err;

    always #5 clk = ~clk;

    bdd_tree_walker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .node_addr    (node_addr),
        .node_req     (node_req),
        .node_thr     (node_thr),
        .node_left    (node_left),
        .node_right   (node_right),
        .node_is_leaf (node_is_leaf),
        .node_class   (node_class),
        .acc          (acc),
        .acc_valid    (acc_valid),
        .class_out    (class_out),
        .class_valid  (class_valid),
        .err          (err)
    );

    // Node table, per-node MAC result and per-node MAC latency (-1: never answers).
    node_t                mem     [256];
    logic [ACC_WIDTH-1:0] acc_tab [256];
    int                   dly_tab [256];

    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat_addr;
    bit   load_pend;
    int   acc_cnt;
    logic [NODE_ADDR_WIDTH-1:0] addr_log[$];
    int   done_cyc, err_cyc, end_cyc, n_cv, n_err;

    typedef struct {
        logic [ACC_WIDTH-1:0]       thr;
        logic [ACC_WIDTH-1:0]       acc;
        int                         dly;
        logic [CLASS_WIDTH-1:0]     exp_cls;
        logic [NODE_ADDR_WIDTH-1:0] exp_leaf;
        int                         exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Node table answers the cycle after node_req; MAC answers dly cycles into WAIT.
    task automatic respond();
        acc_valid = 1'b0;
        if (acc_cnt == 0) begin
            acc_valid = 1'b1;
            acc       = acc_tab[lat_addr];
        end
        if (acc_cnt >= 0) acc_cnt--;
        if (load_pend) begin
            node_thr     = mem[lat_addr].thr;
            node_left    = mem[lat_addr].left;
            node_right   = mem[lat_addr].right;
            node_is_leaf = mem[lat_addr].is_leaf;
            node_class   = mem[lat_addr].cls;
            load_pend    = 1'b0;
            acc_cnt      = dly_tab[lat_addr];
        end
        if (node_req) begin
            lat_addr  = int'(node_addr);
            load_pend = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        respond();
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            acc_tab[i] = '0;
            dly_tab[i] = 0;
        end
    endtask

    task automatic set_node(input int a, input logic [ACC_WIDTH-1:0] thr, input int l, input int r,
                            input logic leaf, input logic [CLASS_WIDTH-1:0] cls);
        mem[a].thr     = thr;
        mem[a].left    = NODE_ADDR_WIDTH'(l);
        mem[a].right   = NODE_ADDR_WIDTH'(r);
        mem[a].is_leaf = leaf;
        mem[a].cls     = cls;
    endtask

    // Called at a negedge while idle: start is raised for cycle 0.
    task automatic run(input int max_cyc, input int s1, input int s2, input bit stray);
        addr_log.delete();
        done_cyc = -1; err_cyc = -1; end_cyc = -1; n_cv = 0; n_err = 0;
        start = 1'b1;
        if (stray) acc_valid = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            cyc();
            if (node_req) addr_log.push_back(node_addr);
            if (class_valid) begin n_cv++; done_cyc = c; end
            if (err) begin n_err++; err_cyc = c; end
            if (!busy) begin
                end_cyc = c;
                break;
            end
            start = (c == s1 || c == s2);
        end
        start = 1'b0;
        if (end_cyc < 0) chk("run_bound_busy", 32'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{20'h00100, 20'h00100, 0,  4'd9, 8'd7, 7};
        vecs[1] = '{20'h00100, 20'h000FF, 0,  4'd2, 8'd3, 7};
        vecs[2] = '{20'h00000, 20'hFFFFF, 3,  4'd9, 8'd7, 10};
        vecs[3] = '{20'hFFFFF, 20'hFFFFE, 1,  4'd2, 8'd3, 8};
        vecs[4] = '{20'hFFFFF, 20'hFFFFF, 14, 4'd9, 8'd7, 21};
        vecs[5] = '{20'h80000, 20'h7FFFF, 2,  4'd2, 8'd3, 9};

        rst_n = 1'b0; start = 1'b0; acc = '0; acc_valid = 1'b0;
        node_thr = '0; node_left = '0; node_right = '0; node_is_leaf = 1'b0; node_class = '0;
        load_pend = 1'b0; acc_cnt = -1; lat_addr = 0;
        clear_mem();
        cyc(); cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_node_req", 32'(node_req), 0);
        chk("rst_class_valid", 32'(class_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_node_addr", 32'(node_addr), 0);
        chk("rst_class_out", 32'(class_out), 0);
        rst_n = 1'b1;
        cyc();
        chk("idle_busy", 32'(busy), 0);

        // Root is a leaf; the MAC still answers during DONE and must be ignored.
        set_node(0, '0, 0, 0, 1'b1, 4'd5);
        run(20, 0, 0, 1'b0);
        chk("leaf_done_cyc", 32'(done_cyc), 3);
        chk("leaf_class", 32'(class_out), 5);
        chk("leaf_nreq", 32'(addr_log.size()), 1);
        chk("leaf_end_cyc", 32'(end_cyc), 4);
        chk("leaf_nerr", 32'(n_err), 0);

        for (int v = 0; v < 6; v++) begin
            clear_mem();
            set_node(0, vecs[v].thr, 3, 7, 1'b0, 4'd0);
            set_node(3, '0, 0, 0, 1'b1, 4'd2);
            set_node(7, '0, 0, 0, 1'b1, 4'd9);
            acc_tab[0] = vecs[v].acc;
            dly_tab[0] = vecs[v].dly;
            run(60, 0, 0, 1'b0);
            chk($sformatf("vec%0d_class", v), 32'(class_out), 32'(vecs[v].exp_cls));
            chk($sformatf("vec%0d_done_cyc", v), 32'(done_cyc), 32'(vecs[v].exp_done));
            chk($sformatf("vec%0d_leaf_addr", v), 32'(node_addr), 32'(vecs[v].exp_leaf));
            chk($sformatf("vec%0d_ncv", v), 32'(n_cv), 1);
            chk($sformatf("vec%0d_nerr", v), 32'(n_err), 0);
            chk($sformatf("vec%0d_end_cyc", v), 32'(end_cyc), 32'(vecs[v].exp_done + 1));
        end

        // Three-level tree: equality at the root goes right, node 7 goes left to leaf 12.
        clear_mem();
        set_node(0, 20'h00100, 3, 7, 1'b0, 4'd0);
        set_node(3, '0, 0, 0, 1'b1, 4'd2);
        set_node(7, 20'h00050, 12, 13, 1'b0, 4'd0);
        set_node(12, '0, 0, 0, 1'b1, 4'd9);
        set_node(13, '0, 0, 0, 1'b1, 4'd4);
        acc_tab[0] = 20'h00100;
        acc_tab[7] = 20'h00010;
        run(60, 0, 0, 1'b0);
        chk("tree3_nreq", 32'(addr_log.size()), 3);
        if (addr_log.size() == 3) begin
            chk("tree3_addr0", 32'(addr_log[0]), 0);
            chk("tree3_addr1", 32'(addr_log[1]), 7);
            chk("tree3_addr2", 32'(addr_log[2]), 12);
        end
        chk("tree3_done_cyc", 32'(done_cyc), 11);
        chk("tree3_class", 32'(class_out), 9);

        // MAC never answers: timeout after 15 WAIT cycles, label preserved.
        clear_mem();
        set_node(0, 20'h00100, 3, 7, 1'b0, 4'd0);
        dly_tab[0] = -1;
        run(60, 0, 0, 1'b0);
        chk("to_err_cyc", 32'(err_cyc), 18);
        chk("to_nerr", 32'(n_err), 1);
        chk("to_ncv", 32'(n_cv), 0);
        chk("to_class_kept", 32'(class_out), 9);
        chk("to_end_cyc", 32'(end_cyc), 19);
        acc_cnt = -1;

        // Self-looping root: depth overflow after 15 decisions; starts while busy ignored.
        clear_mem();
        set_node(0, '0, 0, 0, 1'b0, 4'd0);
        run(200, 10, 30, 1'b0);
        chk("loop_err_cyc", 32'(err_cyc), 61);
        chk("loop_nreq", 32'(addr_log.size()), 15);
        chk("loop_ncv", 32'(n_cv), 0);
        chk("loop_nerr", 32'(n_err), 1);
        chk("loop_end_cyc", 32'(end_cyc), 62);

        // Reset while waiting on node 7, then stray acc_valid, then a clean run.
        clear_mem();
        set_node(0, 20'h00100, 3, 7, 1'b0, 4'd0);
        set_node(3, '0, 0, 0, 1'b1, 4'd2);
        set_node(7, 20'h00050, 12, 13, 1'b0, 4'd0);
        set_node(12, '0, 0, 0, 1'b1, 4'd9);
        set_node(13, '0, 0, 0, 1'b1, 4'd4);
        acc_tab[0] = 20'h00100;
        acc_tab[7] = 20'h00010;
        dly_tab[7] = -1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 2; c <= 9; c++) cyc();
        chk("mid_busy", 32'(busy), 1);
        chk("mid_node_addr", 32'(node_addr), 7);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_node_addr", 32'(node_addr), 0);
        chk("arst_class_out", 32'(class_out), 0);
        chk("arst_node_req", 32'(node_req), 0);
        chk("arst_class_valid", 32'(class_valid), 0);
        chk("arst_err", 32'(err), 0);
        cyc(); cyc();
        load_pend = 1'b0; acc_cnt = -1;
        rst_n = 1'b1;
        acc_valid = 1'b1;
        cyc();
        chk("stray_busy", 32'(busy), 0);
        chk("stray_node_req", 32'(node_req), 0);
        dly_tab[7] = 0;
        run(60, 0, 0, 1'b1);
        chk("post_rst_done_cyc", 32'(done_cyc), 11);
        chk("post_rst_class", 32'(class_out), 9);
        chk("post_rst_nerr", 32'(n_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
